// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon score block.
//   state_t        : game state encoding (IDLE, PLAY, OVER)
//   SCORE_W        : width of score / high score / display value
//   MAX_SCORE_DEF  : default highest reachable score
package simon_pkg;

  localparam int unsigned SCORE_W       = 6;
  localparam int unsigned MAX_SCORE_DEF = 19;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

endpackage

// File: rtl/simon_blink.sv
// simon_blink: tick-divided toggle used to alternate the game-over display.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   clear : synchronous restart; counter to zero, phase to 0
//   tick  : slow time-base enable; each pulse advances the counter
//   phase : flips every BLINK_TICKS tick pulses
module simon_blink #(
  parameter int unsigned BLINK_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic phase
);

  localparam int unsigned CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (cnt == CW'(BLINK_TICKS - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/simon_score.sv
// simon_score: score keeping and score display selection for a Simon game.
// Optional feature macro: SIMON_HIGH_SCORE_EN (high-score register, new_high,
// and score/high-score alternation on the display while in OVER).
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   new_game   : pulse, start a game from any state
//   round_pass : pulse, sequence repeated correctly (counted in PLAY)
//   game_over  : pulse, player failed (honoured in PLAY)
//   tick       : slow enable, only drives the display alternation
//   num        : registered display value
//   playing    : high while in PLAY
//   win        : last game ended by reaching MAX_SCORE
//   new_high   : last game set a new high score
module simon_score
  import simon_pkg::*;
#(
  parameter int unsigned MAX_SCORE   = MAX_SCORE_DEF,
  parameter int unsigned BLINK_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               round_pass,
  input  logic               game_over,
  input  logic               tick,
  output logic [SCORE_W-1:0] num,
  output logic               playing,
  output logic               win,
  output logic               new_high
);

  state_t             state, state_next;
  logic [SCORE_W-1:0] score, score_next;
  logic [SCORE_W-1:0] num_next;
  logic               enter_over;
  logic               reach_max;

  assign playing = (state == PLAY);

  // Priority new_game > game_over > round_pass; a coincident round_pass
  // with game_over is dropped.
  always_comb begin
    state_next = state;
    score_next = score;
    enter_over = 1'b0;
    reach_max  = 1'b0;
    if (new_game) begin
      state_next = PLAY;
      score_next = '0;
    end else if (state == PLAY) begin
      if (game_over) begin
        state_next = OVER;
        enter_over = 1'b1;
      end else if (round_pass) begin
        score_next = score + 1'b1;
        if (score_next == SCORE_W'(MAX_SCORE)) begin
          state_next = OVER;
          enter_over = 1'b1;
          reach_max  = 1'b1;
        end
      end
    end
  end

`ifdef SIMON_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high;
  logic               phase;

  // Held clear outside OVER so every entry to OVER starts on the score.
  simon_blink #(
    .BLINK_TICKS(BLINK_TICKS)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .clear(state != OVER),
    .tick (tick),
    .phase(phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high     <= '0;
      new_high <= 1'b0;
    end else if (new_game) begin
      new_high <= 1'b0;
    end else if (enter_over && (score_next > high)) begin
      high     <= score_next;
      new_high <= 1'b1;
    end
  end

  always_comb begin
    num_next = '0;
    case (state)
      PLAY:    num_next = score;
      OVER:    num_next = phase ? high : score;
      default: num_next = high;
    endcase
  end
`else
  assign new_high = 1'b0;

  always_comb begin
    num_next = '0;
    case (state)
      PLAY, OVER: num_next = score;
      default:    num_next = '0;
    endcase
  end
`endif

  // num is sampled from the current registered state, so it trails the
  // state/score update by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      score <= '0;
      num   <= '0;
      win   <= 1'b0;
    end else begin
      state <= state_next;
      score <= score_next;
      num   <= num_next;
      if (new_game) begin
        win <= 1'b0;
      end else if (enter_over) begin
        win <= reach_max;
      end
    end
  end

endmodule

// File: tb/tb_simon_score.sv
module tb_simon_score;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game, round_pass, game_over, tick;
  logic [5:0] num;
  logic       playing, win, new_high;

  int checks = 0;
  int errors = 0;

`ifdef SIMON_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  simon_score #(
    .MAX_SCORE  (19),
    .BLINK_TICKS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .new_game  (new_game),
    .round_pass(round_pass),
    .game_over (game_over),
    .tick      (tick),
    .num       (num),
    .playing   (playing),
    .win       (win),
    .new_high  (new_high)
  );

  always #5 clk = ~clk;

  // Drive for one cycle starting at a falling edge; returns at the next
  // falling edge (state updated, num still one clock behind).
  task automatic pulse(input logic ng, input logic rp, input logic go, input logic tk);
    new_game = ng; round_pass = rp; game_over = go; tick = tk;
    @(negedge clk);
    new_game = 1'b0; round_pass = 1'b0; game_over = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic passes(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #3;
    checks++; if (num !== 6'd0) begin errors++; $display("FAIL reset_num got %0d exp 0", num); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b exp 0", playing); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win got %b exp 0", win); end
    checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL reset_new_high got %b exp 0", new_high); end
    idle(2);
    rst = 1'b0;
    idle(2);
    checks++; if (num !== 6'd0) begin errors++; $display("FAIL idle_num got %0d exp 0", num); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL idle_playing got %b exp 0", playing); end
  endtask

  task automatic test_count5;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(4);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (num !== 6'd4) begin errors++; $display("FAIL count5_latency got %0d exp 4", num); end
    idle(1);
    checks++; if (num !== 6'd5) begin errors++; $display("FAIL count5_num got %0d exp 5", num); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL count5_playing got %b exp 1", playing); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL count5_win got %b exp 0", win); end
  endtask

  task automatic test_high_score;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(7);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL hs1_playing got %b exp 0", playing); end
    checks++; if (new_high !== HS) begin errors++; $display("FAIL hs1_new_high got %b exp %b", new_high, HS); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL hs1_win got %b exp 0", win); end
    idle(1);
    checks++; if (num !== 6'd7) begin errors++; $display("FAIL hs1_num got %0d exp 7", num); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL hs2_cleared got %b exp 0", new_high); end
    passes(4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL hs2_new_high got %b exp 0", new_high); end
    idle(1);
    checks++; if (num !== 6'd4) begin errors++; $display("FAIL blink_start got %0d exp 4", num); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if (num !== 6'd4) begin errors++; $display("FAIL blink_tick1 got %0d exp 4", num); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if (num !== (HS ? 6'd7 : 6'd4)) begin errors++; $display("FAIL blink_high got %0d exp %0d", num, HS ? 7 : 4); end
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    checks++; if (num !== (HS ? 6'd7 : 6'd4)) begin errors++; $display("FAIL blink_tick3 got %0d exp %0d", num, HS ? 7 : 4); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if (num !== 6'd4) begin errors++; $display("FAIL blink_back got %0d exp 4", num); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL over_ignores got %b exp 0", playing); end
  endtask

  task automatic test_simultaneous;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(7);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL simul_playing got %b exp 0", playing); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL simul_win got %b exp 0", win); end
    checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL simul_tie_new_high got %b exp 0", new_high); end
    idle(1);
    checks++; if (num !== 6'd7) begin errors++; $display("FAIL simul_num got %0d exp 7", num); end
  endtask

  task automatic test_new_game_override;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(10);
    idle(1);
    checks++; if (num !== 6'd10) begin errors++; $display("FAIL ovr_pre got %0d exp 10", num); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL ovr_playing got %b exp 1", playing); end
    idle(1);
    checks++; if (num !== 6'd0) begin errors++; $display("FAIL ovr_num got %0d exp 0", num); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    checks++; if (num !== 6'd1) begin errors++; $display("FAIL ovr_next got %0d exp 1", num); end
  endtask

  task automatic test_mid_reset;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(12);
    idle(1);
    checks++; if (num !== 6'd12) begin errors++; $display("FAIL mid_pre got %0d exp 12", num); end
    #2 rst = 1'b1;
    #1;
    checks++; if (num !== 6'd0) begin errors++; $display("FAIL mid_async_num got %0d exp 0", num); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL mid_async_playing got %b exp 0", playing); end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    checks++; if (num !== 6'd0) begin errors++; $display("FAIL mid_idle_num got %0d exp 0", num); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (new_high !== HS) begin errors++; $display("FAIL mid_high_cleared got %b exp %b", new_high, HS); end
    idle(1);
    checks++; if (num !== 6'd1) begin errors++; $display("FAIL mid_over_num got %0d exp 1", num); end
  endtask

  task automatic test_max;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    passes(18);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL max18_playing got %b exp 1", playing); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL max19_playing got %b exp 0", playing); end
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL max19_win got %b exp 1", win); end
    checks++; if (new_high !== HS) begin errors++; $display("FAIL max19_new_high got %b exp %b", new_high, HS); end
    idle(1);
    checks++; if (num !== 6'd19) begin errors++; $display("FAIL max19_num got %0d exp 19", num); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    checks++; if (num !== 6'd19) begin errors++; $display("FAIL max20_num got %0d exp 19", num); end
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL max20_win got %b exp 1", win); end
  endtask

  initial begin
    rst = 1'b1;
    new_game = 1'b0; round_pass = 1'b0; game_over = 1'b0; tick = 1'b0;
    test_reset();
    test_count5();
    test_high_score();
    test_simultaneous();
    test_new_game_override();
    test_mid_reset();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
